static_clock_divider: RTL and testbench



---
 rtl/static_clock_divider.sv | 40 ++++
 tb/tb_static_clock_divider.sv | 120 ++++++++++++
 2 files changed

// File: rtl/static_clock_divider.sv
// Fixed-ratio clock divider: clk_out has period PRESCALER clk cycles and is low
// for floor(P/2) cycles, then high for ceil(P/2) cycles.
module static_clock_divider #(
  parameter int PRESCALER = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out
);

  localparam int CNT_W = ($clog2(PRESCALER) > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALER - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(PRESCALER / 2);

  if (PRESCALER < 2) begin : g_bad_prescaler
    $error("static_clock_divider: PRESCALER must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;

  // Output is decided from the next count so it lands in the same edge as cnt.
  always_comb begin
    cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    clk_out_d = (cnt_d >= CNT_HALF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_static_clock_divider.sv
// Directed bench: four divider ratios on a shared clock/reset, checked against a
// positional model through an expected-value queue.
module tb_static_clock_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic co2, co4, co10, co5;

  static_clock_divider #(.PRESCALER(2))  u_p2  (.clk(clk), .rst_n(rst_n), .clk_out(co2));
  static_clock_divider #(.PRESCALER(4))  u_p4  (.clk(clk), .rst_n(rst_n), .clk_out(co4));
  static_clock_divider #(.PRESCALER(10)) u_p10 (.clk(clk), .rst_n(rst_n), .clk_out(co10));
  static_clock_divider #(.PRESCALER(5))  u_p5  (.clk(clk), .rst_n(rst_n), .clk_out(co5));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;              // edges since last reset release
  logic [3:0] exp_q[$];   // {p5, p10, p4, p2}
  logic [3:0] prev = 4'b0;
  int rise2, rise4, rise10, rise5, high5;

  function automatic logic model(int p, int edges);
    return (edges % p) >= (p / 2);
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic chk_int(string tag, int obs, int lo, int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One clk edge: drive reset, push the expected outputs, sample after the edge.
  task automatic tick(logic rst_val, bit verbose_chk);
    logic [3:0] e, o;
    @(negedge clk);
    rst_n = rst_val;
    if (!rst_val) begin
      k = 0;
      e = 4'b0000;
    end else begin
      k++;
      e = {model(5, k), model(10, k), model(4, k), model(2, k)};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {co5, co10, co4, co2};
    if (verbose_chk) begin
      chk("p2", o[0], e[0]);
      chk("p4", o[1], e[1]);
      chk("p10", o[2], e[2]);
      chk("p5", o[3], e[3]);
    end else begin
      n_cmp++;
      assert (o === e) else begin
        n_bad++;
        $error("FAIL longrun: observed %b expected %b (k=%0d)", o, e, k);
      end
    end
    if (o[0] && !prev[0]) rise2++;
    if (o[1] && !prev[1]) rise4++;
    if (o[2] && !prev[2]) rise10++;
    if (o[3] && !prev[3]) rise5++;
    if (o[3] === 1'b1) high5++;
    prev = o;
  endtask

  initial begin
    // Reset held for 3 edges: everything low.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    // Release: P=2 toggles, P=4 0,1,1,0..., P=10 rises at edge 5 and 15.
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);

    // Reset again, run to edge 6, then assert reset on the 7th edge while high.
    tick(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    chk("p10_high_before_reset", co10, 1'b1);
    tick(1'b0, 1'b1);
    chk("p10_cnt_zero_on_reset", (u_p10.cnt_q === '0), 1'b1);
    chk("p10_out_zero_on_reset", co10, 1'b0);
    // Restart must repeat the post-reset sequence: rise on 5th edge after release.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    chk("p10_low_edge4", co10, 1'b0);
    tick(1'b1, 1'b1);
    chk("p10_rise_edge5", co10, 1'b1);

    // Long run from a fresh reset.
    tick(1'b0, 1'b1);
    rise2 = 0; rise4 = 0; rise10 = 0; rise5 = 0; high5 = 0;
    for (int i = 0; i < 1000; i++) tick(1'b1, 1'b0);
    chk_int("rise_p2", rise2, 499, 501);
    chk_int("rise_p4", rise4, 249, 251);
    chk_int("rise_p10", rise10, 99, 101);
    chk_int("rise_p5", rise5, 199, 201);
    chk_int("high_p5", high5, 600, 600);
    chk_int("queue_drained", exp_q.size(), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
